// File: rtl/par_rx.sv
// par_rx: receive end of the parallel inter-router channel.
// Channel flits land in a small first-word-fall-through FIFO and are offered
// to the router input port with a req/ack handshake. channel_busy back-pressures
// the sender while the FIFO is full.
// Optional feature macro: PAR_RX_DROP_CNT_EN adds an 8-bit saturating
// drop_count of flits offered while busy.
`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

module par_rx #(
  parameter string       port  = "unknown",
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                valid,
  input  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]  item_in,
  output logic                                channel_busy,
  output logic                                req,
  output logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]  item_out,
`ifdef PAR_RX_DROP_CNT_EN
  output logic [7:0]                          drop_count,
`endif
  input  logic                                ack
);

  localparam int unsigned      FW       = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [FW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Outputs decode registered state only, so no input reaches an output
  assign req          = (count_q != '0);
  assign channel_busy = (count_q == FULL_CNT);
  assign item_out     = mem_q[rd_ptr_q];

  // Handshake qualification and next pointer/occupancy
  always_comb begin
    push     = valid && !channel_busy;
    pop      = req && ack;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage; cleared on reset so item_out reads zero afterwards
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= item_in;
    end
  end

`ifdef PAR_RX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Count flits offered while busy, saturating at 255
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (valid && channel_busy && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // Occupancy never exceeds DEPTH; DEPTH must be 2**PTR_W for pointer wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      assert ((count_q <= FULL_CNT) && (DEPTH == (32'd1 << PTR_W)))
        else $error("par_rx[%s]: occupancy %0d out of range", port, count_q);
    end
  end

endmodule

// File: tb/tb_par_rx.sv
// Bench for par_rx: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the FIFO.
`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

module tb_par_rx;

  localparam int unsigned FW    = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          valid;
  logic [FW-1:0] item_in;
  logic          channel_busy;
  logic          req;
  logic [FW-1:0] item_out;
  logic          ack;
`ifdef PAR_RX_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  par_rx #(.port("tb"), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .item_in      (item_in),
    .channel_busy (channel_busy),
    .req          (req),
    .item_out     (item_out),
`ifdef PAR_RX_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .ack          (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents of the FIFO in arrival order, plus drop tally
  logic [FW-1:0] model_q[$];
  int unsigned   model_drops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, then compare
  task automatic tick(input logic rst_v, input logic v, input logic [FW-1:0] d, input logic a);
    bit was_full;
    bit was_ready;
    reset   = rst_v;
    valid   = v;
    item_in = d;
    ack     = a;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_ready = (model_q.size() != 0);
    if (!rst_v) begin
      model_q.delete();
      model_drops = 0;
    end else begin
      if (v && was_full && model_drops < 255) model_drops++;
      if (was_ready && a) void'(model_q.pop_front());
      if (v && !was_full) model_q.push_back(d);
    end
    @(negedge clk);
    chk("req", 32'(req), 32'(model_q.size() != 0));
    chk("busy", 32'(channel_busy), 32'(model_q.size() == DEPTH));
    if (model_q.size() != 0) chk("head", 32'(item_out), 32'(model_q[0]));
`ifdef PAR_RX_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 32'(model_drops));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv;
    int pa;
    reset = 1'b0; valid = 1'b0; item_in = '0; ack = 1'b0;
    @(negedge clk);

    // Reset held with traffic present
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, FW'('h5A), 1'b1);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_busy", 32'(channel_busy), 32'd0);
      chk("rst_item", 32'(item_out), 32'd0);
    end
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("rel_req", 32'(req), 32'd0);
    chk("rel_item", 32'(item_out), 32'd0);

    // Single flit, fall-through then consume
    tick(1'b1, 1'b1, FW'('h0A1), 1'b0);
    chk("single_req", 32'(req), 32'd1);
    chk("single_item", 32'(item_out), 32'h0A1);
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("single_done", 32'(req), 32'd0);

    // Fill to full, reject one, drain in order
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b1, FW'(i), 1'b0);
    chk("fill_busy", 32'(channel_busy), 32'd1);
    tick(1'b1, 1'b1, FW'('h5), 1'b0);
    chk("full_hold", 32'(channel_busy), 32'd1);
`ifdef PAR_RX_DROP_CNT_EN
    chk("drop_one", 32'(drop_count), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("drain_item", 32'(item_out), 32'(i));
      tick(1'b1, 1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(req), 32'd0);

    // Streaming across pointer wrap with ack every cycle
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, FW'('h10 + i), 1'b1);
      chk("stream_item", 32'(item_out), 32'('h10 + i));
      chk("stream_busy", 32'(channel_busy), 32'd0);
    end
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("stream_empty", 32'(req), 32'd0);

    // Full with simultaneous push and ack
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b1, FW'('h60 + i), 1'b0);
    tick(1'b1, 1'b1, FW'('h77), 1'b1);
    chk("fullpa_busy", 32'(channel_busy), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      chk("fullpa_item", 32'(item_out), 32'('h60 + i));
      tick(1'b1, 1'b0, '0, 1'b1);
    end
    chk("fullpa_cnt3", 32'(req), 32'd0);

    // Reset with flits buffered
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, FW'('h20 + i), 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_item", 32'(item_out), 32'd0);
    tick(1'b1, 1'b1, FW'('h3C), 1'b0);
    chk("midrst_new", 32'(item_out), 32'h03C);
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("midrst_alone", 32'(req), 32'd0);

    // Randomized traffic with shifting valid/ack densities and rare resets
    for (int blk = 0; blk < 20; blk++) begin
      pv = $urandom_range(10, 95);
      pa = $urandom_range(5, 95);
      for (int c = 0; c < 150; c++) begin
        tick(($urandom_range(0, 199) != 0),
             (int'($urandom_range(0, 99)) < pv),
             FW'($urandom),
             (int'($urandom_range(0, 99)) < pa));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/par_rx.md
Name: par_rx

Overview:
- Receive end of the parallel inter-router channel. Accepts one flit per cycle from the channel (`valid` + `item_in`) into a small FIFO.
- Back-pressures the channel with `channel_busy` when the FIFO is full.
- Presents buffered flits to the router input port with a req/ack handshake.
- Flit width is `HDR_SZ + `PL_SZ + `ADDR_SZ (FW below).

Parameters:
- port, "unknown", port label string (debug/display only, no functional effect).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset); one clock, no other clock domains.
- valid  input  1  channel flit valid this cycle.
- item_in  input  FW  channel flit data.
- channel_busy  output  1  high = FIFO full; the sender must not consider the flit taken.
- req  output  1  high = flit available on item_out.
- item_out  output  FW  head-of-FIFO flit.
- ack  input  1  router consumes the head flit this cycle (meaningful only when req=1).

Behaviour:
- Reset (reset==0 at a rising edge):
  - rd_ptr, wr_ptr and count are set to 0.
  - All storage entries are cleared to 0.
  - Outputs after the edge: req=0, channel_busy=0, item_out=0.
  - Reset wins over any concurrent valid/ack. Reset mid-stream discards all buffered flits.
- Push: at a rising edge with valid=1 and channel_busy=0, item_in is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Pop: at a rising edge with req=1 and ack=1, rd_ptr increments modulo DEPTH.
- Ignored inputs:
  - ack while req=0 has no effect.
  - valid while channel_busy=1 is not stored. Sender retention is the transmitter's responsibility.
- count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - count ranges 0..DEPTH; width PTR_W+1.
- Derived outputs (combinational from registered state only; no input-to-output paths):
  - req = (count != 0).
  - channel_busy = (count == DEPTH).
  - item_out = mem[rd_ptr].
- Latency: first-word fall-through. A flit pushed at edge N gives req=1 and item_out=flit in cycle N+1, provided the FIFO was empty.
- Throughput: 1 flit/cycle in and out sustained when neither full nor empty.
- Boundary conditions:
  - Empty + valid + ack in the same cycle: ack ignored, flit stored, count=1.
  - Full + valid + ack in the same cycle: pop happens, push rejected (busy was high), count=DEPTH-1. channel_busy drops the next cycle.
  - Full: holds indefinitely while ack=0. No overwrite.
  - Pointer wrap: after DEPTH pushes wr_ptr returns to 0. Ordering is strictly FIFO across wrap.

Optional Feature:
- Macro: PAR_RX_DROP_CNT_EN.
- Defined:
  - Adds output `drop_count` [7:0].
  - Increments at each rising edge where valid=1 and channel_busy=1.
  - Saturates at 255; cleared to 0 by reset.
  - Adds no effect on the datapath.
- Undefined: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid=1, item_in=0x5A, ack=1 -> req=0, channel_busy=0, item_out=0 throughout and after release.
- Single flit: push 0x0A1 at edge N, ack=0 -> req=1 and item_out=0x0A1 in cycle N+1; ack=1 one cycle -> req=0 next cycle.
- Fill (DEPTH=4): push 0x1,0x2,0x3,0x4 with ack=0 -> channel_busy=1 after the 4th edge; push 0x5 while busy -> not stored. Pop 4 times -> 0x1,0x2,0x3,0x4 in order, then req=0. With PAR_RX_DROP_CNT_EN defined, drop_count=1 after the rejected push.
- Streaming wrap: 10 consecutive pushes 0x10..0x19 with ack=1 every cycle -> out 0x10..0x19 each one cycle after push, count never exceeds 1, channel_busy stays 0.
- Full + simultaneous push/ack: FIFO full, valid=1 item 0x77, ack=1 -> head popped, 0x77 discarded, count=3, channel_busy=0 next cycle.
- Reset mid-operation: 3 flits buffered, reset=0 one edge -> req=0, count=0. A subsequent push of 0x3C appears alone on item_out.
